// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over the PS/2 open-drain pair,
// holding off the mouse receiver for the whole frame.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       rx_inhibit_out,
    output logic       done_out,
    output logic       ack_err_out,
    output logic       timeout_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe_out,
    output logic       ps2_data_oe_out
);
    localparam int TMAX = TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK_WAIT, RELEASE} state_t;

    state_t        state;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, fall, nack;
    logic [FW-1:0] filt_cnt;
    logic [9:0]    frame;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic          data_s, timed;

    assign data_s = data_sync[1];
    assign timed  = state != IDLE && state != INHIBIT;

    // the filtered clock only follows a new level once it has held for FILTER_CYCLES samples
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            fall      <= 1'b0;
            if (clk_sync[1] == clk_filt)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else
                filt_cnt <= filt_cnt + 1'b1;
        end

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            state           <= IDLE;
            ready_out       <= 1'b1;
            rx_inhibit_out  <= 1'b0;
            done_out        <= 1'b0;
            ack_err_out     <= 1'b0;
            timeout_out     <= 1'b0;
            ps2_clk_oe_out  <= 1'b0;
            ps2_data_oe_out <= 1'b0;
            frame           <= '0;
            bit_cnt         <= '0;
            timer           <= '0;
            nack            <= 1'b0;
        end else begin
            done_out    <= 1'b0;
            timeout_out <= 1'b0;
            timer       <= timer + 1'b1;
            if (timed && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                state           <= IDLE;
                ready_out       <= 1'b1;
                rx_inhibit_out  <= 1'b0;
                ps2_clk_oe_out  <= 1'b0;
                ps2_data_oe_out <= 1'b0;
                timeout_out     <= 1'b1;
            end else
                case (state)
                    IDLE: if (valid_in) begin
                        state          <= INHIBIT;
                        ready_out      <= 1'b0;
                        rx_inhibit_out <= 1'b1;
                        ps2_clk_oe_out <= 1'b1;
                        frame          <= {1'b1, ~^data_in, data_in};
                        bit_cnt        <= '0;
                        timer          <= '0;
                    end
                    INHIBIT: if (timer == TW'(INHIBIT_CYCLES - 1)) begin
                        state           <= REQ;
                        ps2_data_oe_out <= 1'b1;
                        timer           <= '0;
                    end
                    REQ: begin
                        state          <= BITS;
                        ps2_clk_oe_out <= 1'b0;
                    end
                    BITS: if (fall) begin
                        ps2_data_oe_out <= ~frame[bit_cnt];
                        bit_cnt         <= bit_cnt + 1'b1;
                        state           <= bit_cnt == 4'd9 ? ACK_WAIT : BITS;
                    end
                    ACK_WAIT: if (fall) begin
                        nack  <= data_s;
                        state <= RELEASE;
                    end
                    RELEASE: if (clk_filt && data_s) begin
                        done_out       <= 1'b1;
                        ack_err_out    <= nack;
                        ready_out      <= 1'b1;
                        rx_inhibit_out <= 1'b0;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter: sends one command byte to a PS/2 mouse (e.g. 0xF4 enable data reporting, 0xFF reset) over the same open-drain clock/data pair that the mouse receive interface listens on. It sits beside the mouse interface on buf_clk (100 MHz) and drives the pmod lines through tri-state buffers at top level. It also tells the receiver to ignore line activity while a transmit frame is in progress.

Parameters:
INHIBIT_CYCLES, 12000, clk_in cycles ps2 clock is held low before request (120 us at 100 MHz)
TIMEOUT_CYCLES, 2000000, max clk_in cycles from request-to-send to ack completion (20 ms)
FILTER_CYCLES, 8, cycles ps2 clock must be stable at a new level before an edge is accepted

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous, active-low reset
data_in  input  8  command byte
valid_in  input  1  request to send data_in
ready_out  output  1  high only in IDLE; byte accepted when valid_in && ready_out
rx_inhibit_out  output  1  high in every non-IDLE state; receiver discards frames
done_out  output  1  one-cycle pulse at frame completion (ack or nack)
ack_err_out  output  1  valid with done_out; 1 = device did not ack
timeout_out  output  1  one-cycle pulse when the frame is abandoned
ps2_clk_in  input  1  raw ps2 clock line (async)
ps2_data_in  input  1  raw ps2 data line (async)
ps2_clk_oe_out  output  1  1 = pull clock low, 0 = release
ps2_data_oe_out  output  1  1 = pull data low, 0 = release

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; ready_out=1; rx_inhibit_out=0; done_out=0; ack_err_out=0; timeout_out=0; both oe outputs=0 immediately, including mid-frame.
- Inputs: each line passes a 2-FF synchronizer, then the clock passes the filter. The filtered level changes only after FILTER_CYCLES consecutive equal synchronized samples. A falling edge is a 1->0 transition of the filtered level.
- Frame register: on accept, latch {stop=1, parity=~^data_in, data_in}, bit counter=0, timeout counter=0.
- States:
  - IDLE: oe both 0; on accept -> INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
  - REQ: data_oe=1 (start bit), clk_oe=1 for one cycle -> BITS with clk_oe=0.
  - BITS: on each filtered falling edge, data_oe = ~frame[cnt] and cnt++. Bits go LSB first: d0..d7, parity, stop. After the 10th edge (stop, data released) -> ACK_WAIT.
  - ACK_WAIT: on the next falling edge, sample synchronized data: 0 -> ack_err=0, 1 -> ack_err=1; -> RELEASE.
  - RELEASE: wait until filtered clock=1 and synchronized data=1; then pulse done_out with ack_err_out -> IDLE.
- Timeout: the counter runs in REQ through RELEASE. When it reaches TIMEOUT_CYCLES, release both lines, pulse timeout_out (done_out not pulsed), -> IDLE. It does not run in INHIBIT.
- ack_err_out holds its value until the next done_out. done_out and timeout_out are mutually exclusive.
- valid_in while not IDLE is ignored and not queued; data_in changes after accept have no effect.
- Device-side clock edges while IDLE are ignored by this block.
- Clock-line glitches shorter than FILTER_CYCLES never advance the bit counter.

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz and acking: data line sampled on device rising edges reads 0,0,1,0,1,1,1,1, parity 0, stop 1. done_out pulses once, ack_err_out=0, rx_inhibit_out high from accept to done.
- INHIBIT_CYCLES=100: clk_oe_out high for exactly 100 cycles after accept, then data_oe_out=1 before clk_oe_out drops.
- Send 0xFF with the device holding data high on the 11th clock: done_out with ack_err_out=1. Parity bit driven = 1 (eight ones).
- Device never clocks, TIMEOUT_CYCLES=5000: timeout_out pulses 5000 cycles after REQ entry, both oe=0, ready_out=1 next cycle, no done_out.
- Assert rst_in low after the 4th bit: both oe drop in the same cycle without a clk edge. After release, ready_out=1 and a new 0xF4 frame completes normally.
- 3-cycle clock low glitches mid-BITS with FILTER_CYCLES=8, plus valid_in=1 with 0x00 during BITS: bit sequence unchanged, 0x00 never sent, exactly one done_out.
